// File: rtl/onedconv_skew_buffers_pkg.sv
// Shared types and helpers for the 1-D convolution input staging bank.
package onedconv_pkg;

    localparam int DW_DEFAULT        = 16;
    localparam int DIM_DEFAULT       = 16;
    localparam int MAX_DEPTH_DEFAULT = 32;
    localparam int LEN_W_DEFAULT     = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A zero depth would select no tap at all, so the smallest usable depth is one.
    function automatic int clamp_depth(input int depth, input int maxDepth);
        if (depth < 1) return 1;
        if (depth > maxDepth) return maxDepth;
        return depth;
    endfunction

endpackage

// File: rtl/onedconv_skew_buffers_if.sv
// Control, ifmap stream, weight load and tap output bundle of the staging bank.
interface onedconv_skew_buffers_if #(
    parameter int DW        = 16,
    parameter int DIM       = 16,
    parameter int MAX_DEPTH = 32,
    parameter int LEN_W     = 10
);
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

    logic                 start;
    logic [LEN_W-1:0]     cfg_len;
    logic [LEN_W-1:0]     cfg_pad;
    logic [DEPTH_W-1:0]   cfg_depth;
    logic                 ifmap_valid;
    logic [DW-1:0]        ifmap_data;
    logic                 ifmap_ready;
    logic                 weight_shift;
    logic                 weight_zero;
    logic [DIM*DW-1:0]    weight_data;
    logic                 busy;
    logic                 done;
    logic                 out_valid;
    logic [DIM*DW-1:0]    ifmap_flat;
    logic [DIM*DW-1:0]    weight_flat;

    modport master (
        output start, cfg_len, cfg_pad, cfg_depth, ifmap_valid, ifmap_data,
               weight_shift, weight_zero, weight_data,
        input  ifmap_ready, busy, done, out_valid, ifmap_flat, weight_flat
    );

    modport slave (
        input  start, cfg_len, cfg_pad, cfg_depth, ifmap_valid, ifmap_data,
               weight_shift, weight_zero, weight_data,
        output ifmap_ready, busy, done, out_valid, ifmap_flat, weight_flat
    );

endinterface

// File: rtl/onedconv_skew_buffers_lane.sv
// One lane shift register with a runtime-selected output tap (word depth_sel-1).
module skew_shift_lane #(
    parameter int DW        = 16,
    parameter int MAX_DEPTH = 32,
    parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic [DW-1:0]      si_i,
    input  logic [DEPTH_W-1:0] depth_sel_i,
    output logic [DW-1:0]      so_o
);

    logic [DW-1:0] taps_q [MAX_DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < MAX_DEPTH; k++) taps_q[k] <= '0;
        end else if (en_i) begin
            taps_q[0] <= si_i;
            for (int k = 1; k < MAX_DEPTH; k++) taps_q[k] <= taps_q[k-1];
        end
    end

    // Compare against depth directly so the select never needs a narrowing index.
    always_comb begin
        so_o = '0;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            if (depth_sel_i == DEPTH_W'(k + 1)) so_o = taps_q[k];
        end
    end

endmodule

// File: rtl/onedconv_skew_buffers.sv
// Input staging bank: frame sequencer with diagonal skew feeding DIM ifmap lanes,
// plus DIM independently loaded weight lanes, all with a shared latched tap depth.
module onedconv_skew_buffers
    import onedconv_pkg::*;
#(
    parameter int DW        = DW_DEFAULT,
    parameter int DIM       = DIM_DEFAULT,
    parameter int MAX_DEPTH = MAX_DEPTH_DEFAULT,
    parameter int LEN_W     = LEN_W_DEFAULT
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    onedconv_skew_buffers_if.slave bus
);

    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam int CNT_W   = LEN_W + 2;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   pad_q, pad_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               outValid_q, outValid_d;

    logic               inWindow;
    logic               advance;
    logic [CNT_W-1:0]   lastIdx;
    logic [CNT_W-1:0]   cfgSpan;
    logic [DW-1:0]      streamWord;
    logic [DIM*DW-1:0]  ifmapTaps;
    logic [DIM*DW-1:0]  weightTaps;

    // Last cycle index of a frame is len + 2*pad + DIM - 2 (data, both pads, skew drain).
    assign lastIdx  = CNT_W'(len_q) + (CNT_W'(pad_q) << 1) + CNT_W'(DIM) - CNT_W'(2);
    assign inWindow = (count_q >= pad_q) &&
                      ({1'b0, count_q} < ({1'b0, pad_q} + {1'b0, len_q}));
    assign advance  = (state_q == ST_RUN) && !(inWindow && !bus.ifmap_valid);
    assign streamWord = inWindow ? bus.ifmap_data : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            len_q      <= '0;
            pad_q      <= '0;
            depth_q    <= DEPTH_W'(MAX_DEPTH);
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            len_q      <= len_d;
            pad_q      <= pad_d;
            depth_q    <= depth_d;
            outValid_q <= outValid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        len_d      = len_q;
        pad_d      = pad_q;
        depth_d    = depth_q;
        outValid_d = advance;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    count_d = '0;
                    len_d   = bus.cfg_len;
                    pad_d   = bus.cfg_pad;
                    depth_d = DEPTH_W'(clamp_depth(int'(bus.cfg_depth), MAX_DEPTH));
                end
            end
            ST_RUN: begin
                if (advance) begin
                    if ({2'b00, count_q} == lastIdx) state_d = ST_DONE;
                    else count_d = count_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        logic          ifmapEn;
        logic [DW-1:0] weightIn;

        assign ifmapEn  = advance && ({2'b00, count_q} >= CNT_W'(i));
        assign weightIn = bus.weight_zero ? '0 : bus.weight_data[i*DW +: DW];

        skew_shift_lane #(.DW(DW), .MAX_DEPTH(MAX_DEPTH)) u_ifmap (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .en_i        (ifmapEn),
            .si_i        (streamWord),
            .depth_sel_i (depth_q),
            .so_o        (ifmapTaps[i*DW +: DW])
        );

        skew_shift_lane #(.DW(DW), .MAX_DEPTH(MAX_DEPTH)) u_weight (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .en_i        (bus.weight_shift),
            .si_i        (weightIn),
            .depth_sel_i (depth_q),
            .so_o        (weightTaps[i*DW +: DW])
        );
    end

    assign bus.ifmap_ready = (state_q == ST_RUN) && inWindow;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.out_valid   = outValid_q;
    assign bus.ifmap_flat  = ifmapTaps;
    assign bus.weight_flat = weightTaps;

    // The counter never wraps, so the caller must keep the whole frame within LEN_W bits.
    assign cfgSpan = CNT_W'(bus.cfg_len) + (CNT_W'(bus.cfg_pad) << 1) + CNT_W'(DIM - 1);

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == ST_IDLE && bus.start) |-> (cfgSpan < (CNT_W'(1) << LEN_W)));

endmodule

// File: tb/tb_onedconv_skew_buffers.sv
// Self-checking bench: a behavioural model pushes expected taps/flags per cycle, tests pop and compare.
module tb_onedconv_skew_buffers;

    localparam int DW        = 16;
    localparam int DIM       = 4;
    localparam int MAX_DEPTH = 32;
    localparam int LEN_W     = 10;
    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_DONE    = 2;

    typedef struct packed {
        logic [DIM*DW-1:0] ifTaps;
        logic [DIM*DW-1:0] wTaps;
        logic              ov;
        logic              busy;
        logic              done;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t expQ[$];

    int            mState, mC, mLen, mPad, mDepth;
    logic [DW-1:0] mIf [DIM][MAX_DEPTH];
    logic [DW-1:0] mW  [DIM][MAX_DEPTH];

    onedconv_skew_buffers_if #(.DW(DW), .DIM(DIM), .MAX_DEPTH(MAX_DEPTH), .LEN_W(LEN_W)) bus ();

    onedconv_skew_buffers #(.DW(DW), .DIM(DIM), .MAX_DEPTH(MAX_DEPTH), .LEN_W(LEN_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DIM*DW-1:0] rep(input logic [DW-1:0] v);
        return {DIM{v}};
    endfunction

    task automatic idle_inputs();
        bus.start        = 1'b0;
        bus.cfg_len      = '0;
        bus.cfg_pad      = '0;
        bus.cfg_depth    = '0;
        bus.ifmap_valid  = 1'b0;
        bus.ifmap_data   = '0;
        bus.weight_shift = 1'b0;
        bus.weight_zero  = 1'b0;
        bus.weight_data  = '0;
    endtask

    task automatic model_reset();
        mState = M_IDLE;
        mC     = 0;
        mLen   = 0;
        mPad   = 0;
        mDepth = MAX_DEPTH;
        for (int i = 0; i < DIM; i++)
            for (int k = 0; k < MAX_DEPTH; k++) begin
                mIf[i][k] = '0;
                mW[i][k]  = '0;
            end
        expQ.delete();
    endtask

    function automatic bit model_ready();
        return (mState == M_RUN) && (mC >= mPad) && (mC < mPad + mLen);
    endfunction

    // Update the model from the inputs now on the bus, clock once, then queue the expected view.
    task automatic step();
        exp_t          e;
        bit            adv;
        bit            inWin;
        logic [DW-1:0] s;
        int            cfgD;
        adv = 1'b0;
        if (bus.weight_shift) begin
            for (int i = 0; i < DIM; i++) begin
                for (int k = MAX_DEPTH - 1; k > 0; k--) mW[i][k] = mW[i][k-1];
                mW[i][0] = bus.weight_zero ? '0 : bus.weight_data[i*DW +: DW];
            end
        end
        if (mState == M_RUN) begin
            inWin = (mC >= mPad) && (mC < mPad + mLen);
            adv   = !(inWin && !bus.ifmap_valid);
            s     = inWin ? bus.ifmap_data : '0;
            if (adv) begin
                for (int i = 0; i < DIM; i++) begin
                    if (mC >= i) begin
                        for (int k = MAX_DEPTH - 1; k > 0; k--) mIf[i][k] = mIf[i][k-1];
                        mIf[i][0] = s;
                    end
                end
                if (mC == mLen + 2 * mPad + DIM - 2) mState = M_DONE;
                else mC = mC + 1;
            end
        end else if (mState == M_DONE) begin
            mState = M_IDLE;
        end else if (bus.start) begin
            cfgD   = int'(bus.cfg_depth);
            mDepth = (cfgD < 1) ? 1 : ((cfgD > MAX_DEPTH) ? MAX_DEPTH : cfgD);
            mLen   = int'(bus.cfg_len);
            mPad   = int'(bus.cfg_pad);
            mC     = 0;
            mState = M_RUN;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < DIM; i++) begin
            e.ifTaps[i*DW +: DW] = mIf[i][mDepth-1];
            e.wTaps[i*DW +: DW]  = mW[i][mDepth-1];
        end
        e.ov   = adv;
        e.busy = (mState != M_IDLE);
        e.done = (mState == M_DONE);
        expQ.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (bus.ifmap_flat !== '0 || bus.weight_flat !== '0) begin
            failures++;
            $display("[TB] FAIL por_taps: got %h/%h required 0", bus.ifmap_flat, bus.weight_flat);
        end
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL por_flags: busy=%b done=%b required 0/0", bus.busy, bus.done);
        end
        if (bus.ifmap_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL por_ready: got %b required 0", bus.ifmap_ready);
        end
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL por_out_valid: got %b required 0", bus.out_valid);
        end
        @(negedge clk) rst_n = 1'b1;

        bus.cfg_len     = 10'd8;
        bus.cfg_pad     = 10'd0;
        bus.cfg_depth   = 6'd1;
        bus.ifmap_valid = 1'b1;
        bus.ifmap_data  = 16'h00A0;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        e = expQ.pop_front();
        checks++;
        if (bus.busy !== e.busy) begin
            failures++;
            $display("[TB] FAIL rst_start_busy: got %b required %b", bus.busy, e.busy);
        end
        for (int k = 0; k < 5; k++) begin
            bus.ifmap_data = 16'h00A0 + DW'(mC);
            step();
            e = expQ.pop_front();
            checks++;
            if (bus.ifmap_flat !== e.ifTaps) begin
                failures++;
                $display("[TB] FAIL rst_prerun_taps c=%0d: got %h required %h", mC, bus.ifmap_flat, e.ifTaps);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.ifmap_flat !== '0) begin
            failures++;
            $display("[TB] FAIL midrun_taps: got %h required 0", bus.ifmap_flat);
        end
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrun_flags: busy=%b done=%b required 0/0", bus.busy, bus.done);
        end
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrun_out_valid: got %b required 0", bus.out_valid);
        end
        model_reset();
        idle_inputs();
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            e = expQ.pop_front();
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== e.busy) begin
                failures++;
                $display("[TB] FAIL post_reset_no_done k=%0d: done=%b busy=%b required 0/%b", k, bus.done, bus.busy, e.busy);
            end
        end
    endtask

    task automatic test_basic_stream();
        exp_t          e;
        logic [DW-1:0] lane0Seen [11];
        logic [DW-1:0] lane0Exp  [7];
        int            doneStep;
        int            doneCount;
        lane0Exp  = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0};
        doneStep  = -1;
        doneCount = 0;
        bus.cfg_len     = 10'd4;
        bus.cfg_pad     = 10'd0;
        bus.cfg_depth   = 6'd1;
        bus.ifmap_valid = 1'b1;
        bus.start       = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            bus.ifmap_data = (mState == M_RUN && mC < 4) ? DW'(mC + 1) : 16'hDEAD;
            step();
            bus.start = 1'b0;
            e = expQ.pop_front();
            checks += 3;
            if (bus.ifmap_flat !== e.ifTaps) begin
                failures++;
                $display("[TB] FAIL basic_taps step %0d: got %h required %h", k, bus.ifmap_flat, e.ifTaps);
            end
            if (bus.out_valid !== e.ov) begin
                failures++;
                $display("[TB] FAIL basic_out_valid step %0d: got %b required %b", k, bus.out_valid, e.ov);
            end
            if ({bus.busy, bus.done} !== {e.busy, e.done}) begin
                failures++;
                $display("[TB] FAIL basic_flags step %0d: got %b%b required %b%b", k, bus.busy, bus.done, e.busy, e.done);
            end
            lane0Seen[k] = bus.ifmap_flat[DW-1:0];
            if (bus.done === 1'b1) begin
                doneCount++;
                if (doneStep < 0) doneStep = k;
            end
            if (k == 4 || k == 5) begin
                checks++;
                if (bus.ifmap_flat[3*DW +: DW] !== ((k == 5) ? 16'd4 : 16'd0)) begin
                    failures++;
                    $display("[TB] FAIL basic_lane3_skew step %0d: got %h required %h", k, bus.ifmap_flat[3*DW +: DW], (k == 5) ? 16'd4 : 16'd0);
                end
            end
        end
        for (int k = 2; k <= 8; k++) begin
            checks++;
            if (lane0Seen[k] !== lane0Exp[k-2]) begin
                failures++;
                $display("[TB] FAIL basic_lane0_seq step %0d: got %h required %h", k, lane0Seen[k], lane0Exp[k-2]);
            end
        end
        checks++;
        if (doneStep != 8 || doneCount != 1) begin
            failures++;
            $display("[TB] FAIL basic_done_cycle: first at %0d count %0d required 8/1", doneStep, doneCount);
        end
    endtask

    task automatic test_padding();
        exp_t          e;
        logic [DW-1:0] d [3];
        logic [DW-1:0] lane0Seen [14];
        logic [DW-1:0] lane0Exp  [7];
        int            readyCount;
        d          = '{16'hFFFE, 16'h7FFF, 16'h8000};
        lane0Exp   = '{16'h0000, 16'h0000, 16'hFFFE, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000};
        readyCount = 0;
        bus.cfg_len     = 10'd3;
        bus.cfg_pad     = 10'd2;
        bus.cfg_depth   = 6'd1;
        bus.ifmap_valid = 1'b1;
        bus.start       = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            bus.ifmap_data = model_ready() ? d[mC-2] : 16'h5A5A;
            checks++;
            if (bus.ifmap_ready !== model_ready()) begin
                failures++;
                $display("[TB] FAIL pad_ready step %0d c=%0d: got %b required %b", k, mC, bus.ifmap_ready, model_ready());
            end
            if (bus.ifmap_ready === 1'b1) readyCount++;
            step();
            bus.start = 1'b0;
            e = expQ.pop_front();
            checks += 2;
            if (bus.ifmap_flat !== e.ifTaps) begin
                failures++;
                $display("[TB] FAIL pad_taps step %0d: got %h required %h", k, bus.ifmap_flat, e.ifTaps);
            end
            if ({bus.out_valid, bus.busy, bus.done} !== {e.ov, e.busy, e.done}) begin
                failures++;
                $display("[TB] FAIL pad_flags step %0d: got %b%b%b required %b%b%b", k, bus.out_valid, bus.busy, bus.done, e.ov, e.busy, e.done);
            end
            lane0Seen[k] = bus.ifmap_flat[DW-1:0];
        end
        for (int k = 2; k <= 8; k++) begin
            checks++;
            if (lane0Seen[k] !== lane0Exp[k-2]) begin
                failures++;
                $display("[TB] FAIL pad_lane0_seq step %0d: got %h required %h", k, lane0Seen[k], lane0Exp[k-2]);
            end
        end
        checks++;
        if (readyCount != 3) begin
            failures++;
            $display("[TB] FAIL pad_ready_count: got %0d required 3", readyCount);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        int   stalls;
        bit   stalled;
        int   doneStep;
        stalls   = 0;
        doneStep = -1;
        bus.cfg_len   = 10'd8;
        bus.cfg_pad   = 10'd0;
        bus.cfg_depth = 6'd1;
        bus.start     = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            stalled = (mState == M_RUN && mC == 3 && stalls < 3);
            if (stalled) stalls++;
            bus.ifmap_valid = !stalled;
            bus.ifmap_data  = 16'h0100 + DW'(mC);
            if (stalled) begin
                checks++;
                if (bus.ifmap_ready !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL stall_ready step %0d: got %b required 1", k, bus.ifmap_ready);
                end
            end
            step();
            bus.start = 1'b0;
            e = expQ.pop_front();
            checks += 2;
            if (bus.ifmap_flat !== e.ifTaps) begin
                failures++;
                $display("[TB] FAIL stall_taps step %0d: got %h required %h", k, bus.ifmap_flat, e.ifTaps);
            end
            if ({bus.out_valid, bus.busy, bus.done} !== {e.ov, e.busy, e.done}) begin
                failures++;
                $display("[TB] FAIL stall_flags step %0d: got %b%b%b required %b%b%b", k, bus.out_valid, bus.busy, bus.done, e.ov, e.busy, e.done);
            end
            if (stalled) begin
                checks += 2;
                if (bus.out_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stall_out_valid step %0d: got %b required 0", k, bus.out_valid);
                end
                if (bus.ifmap_flat !== {16'h0000, 16'h0102, 16'h0102, 16'h0102}) begin
                    failures++;
                    $display("[TB] FAIL stall_frozen step %0d: got %h required 0000010201020102", k, bus.ifmap_flat);
                end
            end
            if (bus.done === 1'b1 && doneStep < 0) doneStep = k;
        end
        checks++;
        if (doneStep != 15) begin
            failures++;
            $display("[TB] FAIL stall_done_cycle: got %0d required 15", doneStep);
        end
    endtask

    task automatic test_weights();
        exp_t              e;
        logic [DW-1:0]     wData [4];
        logic              wZero [4];
        logic [DIM*DW-1:0] wExp  [4];
        wData = '{16'd1, 16'd2, 16'd3, 16'h7777};
        wZero = '{1'b0, 1'b0, 1'b0, 1'b1};
        wExp  = '{rep(16'd0), rep(16'd0), rep(16'd1), rep(16'd2)};
        bus.cfg_len     = 10'd0;
        bus.cfg_pad     = 10'd0;
        bus.cfg_depth   = 6'd3;
        bus.ifmap_valid = 1'b0;
        bus.start       = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            bus.start = 1'b0;
            e = expQ.pop_front();
            checks++;
            if ({bus.ifmap_flat, bus.busy, bus.done} !== {e.ifTaps, e.busy, e.done}) begin
                failures++;
                $display("[TB] FAIL w_frame step %0d: taps %h busy %b done %b required %h %b %b", k, bus.ifmap_flat, bus.busy, bus.done, e.ifTaps, e.busy, e.done);
            end
        end
        for (int k = 0; k < 4; k++) begin
            bus.weight_shift = 1'b1;
            bus.weight_zero  = wZero[k];
            bus.weight_data  = rep(wData[k]);
            step();
            e = expQ.pop_front();
            checks += 2;
            if (bus.weight_flat !== wExp[k]) begin
                failures++;
                $display("[TB] FAIL w_depth3 shift %0d: got %h required %h", k + 1, bus.weight_flat, wExp[k]);
            end
            if (bus.weight_flat !== e.wTaps) begin
                failures++;
                $display("[TB] FAIL w_model shift %0d: got %h required %h", k + 1, bus.weight_flat, e.wTaps);
            end
        end
        bus.weight_zero = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.weight_shift = (k != 1);
            bus.weight_data  = {16'h4000 + DW'(k), 16'h3000 + DW'(k), 16'h2000 + DW'(k), 16'h1000 + DW'(k)};
            step();
            e = expQ.pop_front();
            checks++;
            if (bus.weight_flat !== e.wTaps) begin
                failures++;
                $display("[TB] FAIL w_lanes k=%0d: got %h required %h", k, bus.weight_flat, e.wTaps);
            end
        end
        bus.weight_shift = 1'b0;
    endtask

    task automatic test_start_ignored_clamp();
        exp_t e;
        int   doneStep;
        doneStep = -1;
        bus.ifmap_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            bus.ifmap_data   = model_ready() ? 16'h0030 + DW'(mC) : 16'hBEEF;
            bus.weight_shift = (k == 4 || k == 5);
            bus.weight_zero  = 1'b0;
            bus.weight_data  = rep((k == 4) ? 16'd5 : 16'd6);
            if (k == 1) begin
                bus.start     = 1'b1;
                bus.cfg_len   = 10'd4;
                bus.cfg_pad   = 10'd0;
                bus.cfg_depth = 6'd0;
            end else if (k == 3) begin
                bus.start     = 1'b1;
                bus.cfg_len   = 10'd9;
                bus.cfg_depth = 6'd40;
            end else begin
                bus.start = (mState == M_DONE);
            end
            step();
            e = expQ.pop_front();
            checks += 3;
            if (bus.ifmap_flat !== e.ifTaps || bus.weight_flat !== e.wTaps) begin
                failures++;
                $display("[TB] FAIL ign_taps step %0d: got %h/%h required %h/%h", k, bus.ifmap_flat, bus.weight_flat, e.ifTaps, e.wTaps);
            end
            if (bus.out_valid !== e.ov) begin
                failures++;
                $display("[TB] FAIL ign_out_valid step %0d: got %b required %b", k, bus.out_valid, e.ov);
            end
            if ({bus.busy, bus.done} !== {e.busy, e.done}) begin
                failures++;
                $display("[TB] FAIL ign_flags step %0d: got %b%b required %b%b", k, bus.busy, bus.done, e.busy, e.done);
            end
            if (bus.done === 1'b1 && doneStep < 0) doneStep = k;
            if (k == 5) begin
                checks++;
                if (bus.weight_flat !== rep(16'd6)) begin
                    failures++;
                    $display("[TB] FAIL clamp_depth0: got %h required %h", bus.weight_flat, rep(16'd6));
                end
            end
            if (k == 9) begin
                checks++;
                if (bus.busy !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL start_in_done: busy got %b required 0", bus.busy);
                end
            end
        end
        checks++;
        if (doneStep != 8) begin
            failures++;
            $display("[TB] FAIL ign_done_cycle: got %0d required 8", doneStep);
        end

        bus.weight_shift = 1'b0;
        bus.cfg_len      = 10'd0;
        bus.cfg_pad      = 10'd0;
        bus.cfg_depth    = 6'd40;
        bus.start        = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            bus.start = 1'b0;
            e = expQ.pop_front();
            checks++;
            if ({bus.busy, bus.done} !== {e.busy, e.done}) begin
                failures++;
                $display("[TB] FAIL clamp_frame step %0d: got %b%b required %b%b", k, bus.busy, bus.done, e.busy, e.done);
            end
        end
        bus.weight_shift = 1'b1;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            bus.weight_data = rep(DW'(k + 1));
            step();
            e = expQ.pop_front();
            checks++;
            if (bus.weight_flat !== e.wTaps) begin
                failures++;
                $display("[TB] FAIL clamp_max_model shift %0d: got %h required %h", k + 1, bus.weight_flat, e.wTaps);
            end
        end
        bus.weight_shift = 1'b0;
        checks++;
        if (bus.weight_flat !== rep(16'd1)) begin
            failures++;
            $display("[TB] FAIL clamp_depth40: got %h required %h", bus.weight_flat, rep(16'd1));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic_stream();
        test_padding();
        test_stall();
        test_weights();
        test_start_ignored_clamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
